// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the single-port data memory: port 0 has priority,
// port 1 is guaranteed a grant after STARVE_LIMIT consecutive contested losses.
module data_mem_arbiter #(
  parameter int bus          = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CW           = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           r0_req,
  input  logic           r0_we,
  input  logic [bus-1:0] r0_addr,
  input  logic [bus-1:0] r0_wdata,
  output logic           r0_gnt,
  output logic           r0_rvalid,
  output logic [bus-1:0] r0_rdata,
  input  logic           r1_req,
  input  logic           r1_we,
  input  logic [bus-1:0] r1_addr,
  input  logic [bus-1:0] r1_wdata,
  output logic           r1_gnt,
  output logic           r1_rvalid,
  output logic [bus-1:0] r1_rdata,
  output logic [bus-1:0] mem_datain,
  output logic [bus-1:0] mem_writedir,
  output logic [bus-1:0] mem_readdir,
  output logic           mem_MRE,
  output logic           mem_MWE,
  input  logic [bus-1:0] mem_dataout
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_RD0  = 2'd1,
    TAG_RD1  = 2'd2
  } tag_t;

  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  tag_t          tag_q, tag_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          force_r1;
  logic          both_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q        <= TAG_NONE;
      starve_cnt_q <= '0;
    end else begin
      tag_q        <= tag_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    both_req     = r0_req & r1_req;
    force_r1     = (starve_cnt_q == LIMIT);
    r1_gnt       = 1'b0;
    r0_gnt       = 1'b0;
    starve_cnt_d = starve_cnt_q;
    tag_d        = TAG_NONE;

    // No grants while reset is held so no stray memory command escapes.
    if (!rst) begin
      r1_gnt = r1_req & (~r0_req | force_r1);
      r0_gnt = r0_req & ~r1_gnt;
    end

    if (r1_gnt) begin
      starve_cnt_d = '0;
    end else if (both_req && r0_gnt && starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end

    if (r0_gnt && !r0_we) begin
      tag_d = TAG_RD0;
    end else if (r1_gnt && !r1_we) begin
      tag_d = TAG_RD1;
    end
  end

  always_comb begin
    mem_datain   = '0;
    mem_writedir = '0;
    mem_readdir  = '0;
    mem_MRE      = 1'b0;
    mem_MWE      = 1'b0;
    if (r0_gnt) begin
      mem_datain   = r0_wdata;
      mem_writedir = r0_addr;
      mem_readdir  = r0_addr;
      mem_MRE      = ~r0_we;
      mem_MWE      = r0_we;
    end else if (r1_gnt) begin
      mem_datain   = r1_wdata;
      mem_writedir = r1_addr;
      mem_readdir  = r1_addr;
      mem_MRE      = ~r1_we;
      mem_MWE      = r1_we;
    end
  end

  always_comb begin
    r0_rvalid = (tag_q == TAG_RD0);
    r1_rvalid = (tag_q == TAG_RD1);
    r0_rdata  = r0_rvalid ? mem_dataout : '0;
    r1_rdata  = r1_rvalid ? mem_dataout : '0;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small behavioural data memory
// (registered read at posedge, write at negedge).
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata;
  logic [31:0] mem_datain, mem_writedir, mem_readdir, mem_dataout;
  logic        mem_MRE, mem_MWE;

  logic [31:0] mem [16];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_datain(mem_datain), .mem_writedir(mem_writedir), .mem_readdir(mem_readdir),
    .mem_MRE(mem_MRE), .mem_MWE(mem_MWE), .mem_dataout(mem_dataout)
  );

  // Behavioural memory standing in for the real data RAM.
  always @(posedge clk) begin
    if (mem_MRE) mem_dataout <= mem[mem_readdir[3:0]];
  end

  always @(negedge clk) begin
    if (mem_MWE) mem[mem_writedir[3:0]] <= mem_datain;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic q0, input logic w0, input logic [31:0] a0,
                               input logic [31:0] d0, input logic q1, input logic w1,
                               input logic [31:0] a1, input logic [31:0] d1);
    r0_req = q0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
    r1_req = q1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
    #2;
  endtask

  // Inputs change 1 time unit after posedge; checks happen 2 units later.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r1Count;
    logic prevGnt1;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[1] = 32'h1111_1111;
    mem[2] = 32'h2222_2222;
    mem_dataout = 32'h0;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0);
    checkOutput("rst_r0_gnt", {31'd0, r0_gnt}, 32'd0);
    checkOutput("rst_r1_gnt", {31'd0, r1_gnt}, 32'd0);
    checkOutput("rst_mre", {31'd0, mem_MRE}, 32'd0);
    checkOutput("rst_mwe", {31'd0, mem_MWE}, 32'd0);
    checkOutput("rst_r0_rvalid", {31'd0, r0_rvalid}, 32'd0);
    checkOutput("rst_r1_rdata", r1_rdata, 32'd0);
    nextCycle();
    rst = 1'b0;

    // Single port write then read back.
    applyStimulus(1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("wr_r0_gnt", {31'd0, r0_gnt}, 32'd1);
    checkOutput("wr_mwe", {31'd0, mem_MWE}, 32'd1);
    checkOutput("wr_mre", {31'd0, mem_MRE}, 32'd0);
    checkOutput("wr_writedir", mem_writedir, 32'd5);
    checkOutput("wr_datain", mem_datain, 32'hDEAD_BEEF);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("rd_r0_gnt", {31'd0, r0_gnt}, 32'd1);
    checkOutput("rd_mre", {31'd0, mem_MRE}, 32'd1);
    checkOutput("rd_readdir", mem_readdir, 32'd5);
    checkOutput("rd_r0_rvalid_early", {31'd0, r0_rvalid}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("rd_r0_rvalid", {31'd0, r0_rvalid}, 32'd1);
    checkOutput("rd_r0_rdata", r0_rdata, 32'hDEAD_BEEF);
    checkOutput("rd_r1_rvalid", {31'd0, r1_rvalid}, 32'd0);
    checkOutput("idle_mre", {31'd0, mem_MRE}, 32'd0);
    checkOutput("idle_readdir", mem_readdir, 32'd0);
    nextCycle();

    // Reset asserted while a port-0 read is in flight.
    applyStimulus(1'b1, 1'b0, 32'd1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("midrd_r0_gnt", {31'd0, r0_gnt}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrd_gnt_in_rst", {31'd0, r0_gnt}, 32'd0);
    checkOutput("midrd_mre_in_rst", {31'd0, mem_MRE}, 32'd0);
    nextCycle();
    checkOutput("midrd_r0_rvalid", {31'd0, r0_rvalid}, 32'd0);
    checkOutput("midrd_r0_rdata", r0_rdata, 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    nextCycle();

    // Continuous contention: grants 0,0,0,0,1 repeating, reads pipelined.
    r1Count = 0;
    prevGnt1 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0);
      checkOutput($sformatf("cont_r1_gnt_%0d", k), {31'd0, r1_gnt}, (k % 5 == 4) ? 32'd1 : 32'd0);
      checkOutput($sformatf("cont_r0_gnt_%0d", k), {31'd0, r0_gnt}, (k % 5 == 4) ? 32'd0 : 32'd1);
      if (k > 0) begin
        checkOutput($sformatf("cont_r0_rdata_%0d", k), r0_rdata,
                    prevGnt1 ? 32'd0 : 32'h1111_1111);
        checkOutput($sformatf("cont_r1_rdata_%0d", k), r1_rdata,
                    prevGnt1 ? 32'h2222_2222 : 32'd0);
      end
      if (r1_gnt) r1Count++;
      prevGnt1 = (k % 5 == 4);
      nextCycle();
    end
    checkOutput("cont_r1_count", r1Count, 32'd2);

    // Alternating single requests: rvalid alternates, each port gets its own data.
    for (int k = 0; k < 5; k++) begin
      if (k < 4)
        applyStimulus(k % 2 == 0, 1'b0, 32'd1, 32'd0, k % 2 == 1, 1'b0, 32'd2, 32'd0);
      else
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      if (k > 0) begin
        checkOutput($sformatf("alt_r0_rvalid_%0d", k), {31'd0, r0_rvalid}, (k % 2 == 1) ? 32'd1 : 32'd0);
        checkOutput($sformatf("alt_r1_rvalid_%0d", k), {31'd0, r1_rvalid}, (k % 2 == 0) ? 32'd1 : 32'd0);
        checkOutput($sformatf("alt_r0_rdata_%0d", k), r0_rdata, (k % 2 == 1) ? 32'h1111_1111 : 32'd0);
        checkOutput($sformatf("alt_r1_rdata_%0d", k), r1_rdata, (k % 2 == 0) ? 32'h2222_2222 : 32'd0);
      end
      nextCycle();
    end

    // Counter cleared by an uncontested port-1 grant.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0);
      checkOutput($sformatf("ctr_pre_r0_gnt_%0d", k), {31'd0, r0_gnt}, 32'd1);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0);
    checkOutput("ctr_alone_r1_gnt", {31'd0, r1_gnt}, 32'd1);
    nextCycle();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0);
      checkOutput($sformatf("ctr_post_r1_gnt_%0d", k), {31'd0, r1_gnt}, (k == 4) ? 32'd1 : 32'd0);
      nextCycle();
    end

    // Write by port 1 followed immediately by a port-0 read of the same word.
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd9, 32'h12);
    checkOutput("haz_r1_gnt", {31'd0, r1_gnt}, 32'd1);
    checkOutput("haz_mwe", {31'd0, mem_MWE}, 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'd9, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("haz_r0_gnt", {31'd0, r0_gnt}, 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("haz_r0_rvalid", {31'd0, r0_rvalid}, 32'd1);
    checkOutput("haz_r0_rdata", r0_rdata, 32'h12);
    nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
